sort_n_floats_using_fsm: RTL and testbench
==========================================

Name: sort_n_floats_using_fsm

Overview:
- Sorts N floating-point numbers (FLEN bits each) into ascending or descending order with a multi-cycle bubble-sort FSM.
- Uses one externally instantiated f_less_or_equal comparator through its a/b/res/err interface. The block itself instantiates no modules.
- This is the parametrised successor of the fixed 3-element float sorter: it adds element count N, a runtime order mode, sticky error reporting and deterministic latency.
- It sits in the FP test datapath next to the shared comparator.

Parameters:
- N, 4, number of elements to sort; legal range 2..16.
- FLEN, from config-shared.vh (64), float width; not redeclared in this block.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- valid_in  input  1  input vector valid; accepted only when busy=0.
- descending  input  1  order mode, sampled at accept (0=ascending, 1=descending).
- unsorted  input  [0:N-1][FLEN-1:0]  input vector.
- valid_out  output  1  one-cycle pulse; sorted and err are valid.
- sorted  output  [0:N-1][FLEN-1:0]  result, registered; holds until the next accept.
- err  output  1  OR of f_le_err over all compares of the current job; registered.
- busy  output  1  high whenever state != IDLE.
- f_le_a  output  FLEN  comparator operand a (combinational).
- f_le_b  output  FLEN  comparator operand b (combinational).
- f_le_res  input  1  a<=b; combinational response in the same cycle.
- f_le_err  input  1  comparator error (NaN operand); same cycle.

Behaviour:
- Reset values: state=IDLE, valid_out=0, err=0, sorted=0, internal buffer=0, pass=0, j=0. f_le_a and f_le_b are 0 outside the COMPARE state.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - If valid_in=1: load buffer<=unsorted, latch descending, clear err_acc, set pass=0 and j=0, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE:
  - Drive f_le_a=buf[j] and f_le_b=buf[j+1].
  - swap = !f_le_err & (descending ? f_le_res : !f_le_res). If swap=1, exchange buf[j] and buf[j+1].
  - err_acc |= f_le_err. When f_le_err=1 the pair is never swapped.
  - If j < N-2-pass: j++.
  - Else if pass == N-2: go to DONE.
  - Else: pass++, j=0.
- DONE:
  - sorted<=buf, err<=err_acc, valid_out<=1 for one cycle.
  - Go to IDLE. busy is low from the following cycle.
- Latency is fixed regardless of data:
  - C = N(N-1)/2 compare cycles.
  - valid_in accepted at edge T, valid_out high in cycle T+C+1.
  - N=3: T+4. N=4: T+7.
  - No early exit.
- valid_in while busy=1 is ignored; there is no queueing. The earliest new accept is the cycle after valid_out.
- Counter widths are $clog2(N) bits. pass and j never wrap past N-2.
- Equal keys (including +0/-0):
  - Ascending: never swapped (stable).
  - Descending: always swapped (not stable). Bit patterns are preserved.
- Reset asserted in any state returns to IDLE on the next edge. valid_out=0, err=0, the in-flight job is discarded and sorted is cleared.
- err and sorted hold their values between jobs. err is cleared only at the next DONE that has a clean result, or at reset.

Decomposition:
- Package sort_fsm_pkg contains:
  - the state enum sort_state_t (IDLE, COMPARE, DONE);
  - function num_compares(n) returning n*(n-1)/2, used by the bench for latency checks.
- No sub-module. The single FSM plus the buffer fits in one module, and the comparator stays external by requirement.

Test Plan:
- N=4, ascending, unsorted={3.0,-1.0,2.0,1.0} (0x4008..,0xBFF0..,0x4000..,0x3FF0..):
  - valid_out exactly at T+7;
  - sorted={-1.0,1.0,2.0,3.0};
  - err=0;
  - busy high in cycles T+1..T+7.
- Same input with descending=1 -> sorted={3.0,2.0,1.0,-1.0} at T+7, err=0.
- Input with NaN 0x7FF8000000000000 at index 1 -> err=1 at valid_out, NaN never swapped on an erroring compare; next clean job -> err=0.
- Pulse valid_in again at T+3 during a job -> ignored; exactly one valid_out; a new accept at T+8 succeeds with valid_out at T+15.
- Assert rst at T+4 mid-job -> no valid_out, sorted=0, busy=0 the cycle after reset; a following job completes normally.
- N=2 and N=16 builds with random vectors against a reference model:
  - latency 2 and 121 respectively;
  - already-sorted and reverse-sorted inputs included.

Source files
------------

// File: rtl/sort_n_floats_using_fsm_pkg.sv
// Shared types for the N-element float bubble sorter: FSM state encoding,
// the common FP width and the compare-count helper used for latency budgeting.
package sort_fsm_pkg;

    // Shared FP datapath width (matches the comparator's operand width).
    localparam int FLEN = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } sort_state_t;

    // Number of compare cycles a full bubble sort of n elements takes.
    function automatic int num_compares(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sort_n_floats_using_fsm_if.sv
// Job bundle (vector in, sorted vector out) and the bundle towards the
// shared external f_less_or_equal comparator.
interface sort_n_floats_using_fsm_if #(
    parameter int N = 4
);
    import sort_fsm_pkg::*;

    logic                      valid_in;
    logic                      descending;
    logic [0:N-1][FLEN-1:0]    unsorted;
    logic                      valid_out;
    logic [0:N-1][FLEN-1:0]    sorted;
    logic                      err;
    logic                      busy;

    modport master (
        output valid_in, descending, unsorted,
        input  valid_out, sorted, err, busy
    );

    modport slave (
        input  valid_in, descending, unsorted,
        output valid_out, sorted, err, busy
    );
endinterface

interface f_le_if;
    import sort_fsm_pkg::*;

    logic [FLEN-1:0] f_le_a;
    logic [FLEN-1:0] f_le_b;
    logic            f_le_res;
    logic            f_le_err;

    // The sorter drives operands; the comparator answers in the same cycle.
    modport master (
        output f_le_a, f_le_b,
        input  f_le_res, f_le_err
    );

    modport slave (
        input  f_le_a, f_le_b,
        output f_le_res, f_le_err
    );
endinterface

// File: rtl/sort_n_floats_using_fsm.sv
// Multi-cycle bubble sort of N floats through one external comparator;
// fixed latency of N(N-1)/2 compare cycles plus one DONE cycle.
module sort_n_floats_using_fsm
    import sort_fsm_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    sort_n_floats_using_fsm_if.slave     io,
    f_le_if.master                       cmp
);

    localparam int              CW        = $clog2(N);
    localparam logic [CW-1:0]   PASS_LAST = CW'(N - 2);

    typedef logic [0:N-1][FLEN-1:0] vec_t;

    sort_state_t      state_reg, state_next;
    vec_t             data_reg, data_next;
    vec_t             sorted_reg, sorted_next;
    logic             desc_reg, desc_next;
    logic             err_acc_reg, err_acc_next;
    logic             err_reg, err_next;
    logic             valid_out_reg, valid_out_next;
    logic [CW-1:0]    pass_reg, pass_next;
    logic [CW-1:0]    j_reg, j_next;
    logic [CW-1:0]    j_inc, j_last;
    logic [FLEN-1:0]  a_val, b_val;
    logic             swap;

    assign j_inc  = j_reg + CW'(1);
    assign j_last = PASS_LAST - pass_reg;
    assign a_val  = data_reg[j_reg];
    assign b_val  = data_reg[j_inc];

    assign cmp.f_le_a = (state_reg == COMPARE) ? a_val : '0;
    assign cmp.f_le_b = (state_reg == COMPARE) ? b_val : '0;

    // An erroring compare (NaN operand) never moves the pair.
    assign swap = (state_reg == COMPARE) && !cmp.f_le_err &&
                  (desc_reg ? cmp.f_le_res : !cmp.f_le_res);

    assign io.busy      = (state_reg != IDLE);
    assign io.valid_out = valid_out_reg;
    assign io.sorted    = sorted_reg;
    assign io.err       = err_reg;

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        desc_next      = desc_reg;
        err_acc_next   = err_acc_reg;
        pass_next      = pass_reg;
        j_next         = j_reg;
        sorted_next    = sorted_reg;
        err_next       = err_reg;
        valid_out_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (io.valid_in) begin
                    data_next    = io.unsorted;
                    desc_next    = io.descending;
                    err_acc_next = 1'b0;
                    pass_next    = '0;
                    j_next       = '0;
                    state_next   = COMPARE;
                end
            end

            COMPARE: begin
                if (swap) begin
                    data_next[j_reg] = b_val;
                    data_next[j_inc] = a_val;
                end
                err_acc_next = err_acc_reg | cmp.f_le_err;

                if (j_reg != j_last) begin
                    j_next = j_inc;
                end else if (pass_reg == PASS_LAST) begin
                    // Result registers load on entry to DONE so that
                    // valid_out, sorted and err are all visible in DONE.
                    state_next     = DONE;
                    sorted_next    = data_next;
                    err_next       = err_acc_next;
                    valid_out_next = 1'b1;
                end else begin
                    pass_next = pass_reg + CW'(1);
                    j_next    = '0;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            desc_reg      <= 1'b0;
            err_acc_reg   <= 1'b0;
            pass_reg      <= '0;
            j_reg         <= '0;
            sorted_reg    <= '0;
            err_reg       <= 1'b0;
            valid_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            desc_reg      <= desc_next;
            err_acc_reg   <= err_acc_next;
            pass_reg      <= pass_next;
            j_reg         <= j_next;
            sorted_reg    <= sorted_next;
            err_reg       <= err_next;
            valid_out_reg <= valid_out_next;
        end
    end

endmodule

// File: tb/tb_sort_n_floats_using_fsm.sv
// Bench for the float sorter: N=4, N=2 and N=16 instances, each checked every
// cycle against a queue-free sorting model and hand-computed directed results.
module tb_sort_n_floats_using_fsm;
    import sort_fsm_pkg::*;

    typedef logic [63:0] vec_t [16];

    localparam logic [63:0] P3   = 64'h4008000000000000;
    localparam logic [63:0] M1   = 64'hBFF0000000000000;
    localparam logic [63:0] P2   = 64'h4000000000000000;
    localparam logic [63:0] P1   = 64'h3FF0000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] PZ   = 64'h0000000000000000;
    localparam logic [63:0] MZ   = 64'h8000000000000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int nn[3]      = '{4, 2, 16};
    int lat_lit[3] = '{7, 2, 121};

    logic        drv_valid[3];
    logic        drv_desc[3];
    logic [63:0] drv_vec[3][16];
    logic        mon_valid[3];
    logic        mon_err[3];
    logic        mon_busy[3];
    logic [63:0] mon_sorted[3][16];

    int   acc_cyc[3];
    int   busy_end[3];
    int   exp_cyc[3];
    int   reset_cyc;
    vec_t exp_vec[3];
    vec_t hold_vec[3];
    logic exp_err[3];
    logic hold_err[3];
    bit   chk_on = 1'b0;

    // Reference comparator: returns {err, a<=b}, IEEE-754 double semantics.
    function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
        bit na, nb;
        na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (na || nb) return 2'b10;
        if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 2'b01;
        if (a[63] != b[63]) return {1'b0, a[63]};
        if (!a[63]) return {1'b0, a[62:0] <= b[62:0]};
        return {1'b0, a[62:0] >= b[62:0]};
    endfunction

    // Stable ascending insertion sort; descending = its reverse (distinct keys).
    function automatic vec_t model_sort(input vec_t v, input int n, input bit desc);
        vec_t s, r;
        logic [63:0] key;
        int j;
        for (int e = 0; e < 16; e++) s[e] = (e < n) ? v[e] : 64'd0;
        for (int i = 1; i < n; i++) begin
            key = s[i];
            j = i - 1;
            while (j >= 0 && fle(s[j], key) == 2'b00) begin
                s[j + 1] = s[j];
                j--;
            end
            s[j + 1] = key;
        end
        r = s;
        if (desc) for (int i = 0; i < n; i++) r[i] = s[n - 1 - i];
        return r;
    endfunction

    function automatic vec_t mk4(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [63:0] d);
        vec_t v;
        for (int e = 0; e < 16; e++) v[e] = 64'd0;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic logic [63:0] rnd_f();
        logic [63:0] x;
        x[63]    = 1'($urandom_range(0, 1));
        x[62:52] = 11'($urandom_range(0, 2046));
        x[51:32] = 20'($urandom);
        x[31:0]  = $urandom;
        return x;
    endfunction

    // DUT instances and their comparator models
    sort_n_floats_using_fsm_if #(.N(4))  io4 ();
    sort_n_floats_using_fsm_if #(.N(2))  io2 ();
    sort_n_floats_using_fsm_if #(.N(16)) io16 ();
    f_le_if c4 ();
    f_le_if c2 ();
    f_le_if c16 ();

    sort_n_floats_using_fsm #(.N(4))  dut4  (.clk(clk), .rst(rst), .io(io4),  .cmp(c4));
    sort_n_floats_using_fsm #(.N(2))  dut2  (.clk(clk), .rst(rst), .io(io2),  .cmp(c2));
    sort_n_floats_using_fsm #(.N(16)) dut16 (.clk(clk), .rst(rst), .io(io16), .cmp(c16));

    assign {c4.f_le_err,  c4.f_le_res}  = fle(c4.f_le_a,  c4.f_le_b);
    assign {c2.f_le_err,  c2.f_le_res}  = fle(c2.f_le_a,  c2.f_le_b);
    assign {c16.f_le_err, c16.f_le_res} = fle(c16.f_le_a, c16.f_le_b);

    assign io4.valid_in    = drv_valid[0];
    assign io4.descending  = drv_desc[0];
    assign io2.valid_in    = drv_valid[1];
    assign io2.descending  = drv_desc[1];
    assign io16.valid_in   = drv_valid[2];
    assign io16.descending = drv_desc[2];

    always_comb for (int e = 0; e < 4;  e++) io4.unsorted[e]  = drv_vec[0][e];
    always_comb for (int e = 0; e < 2;  e++) io2.unsorted[e]  = drv_vec[1][e];
    always_comb for (int e = 0; e < 16; e++) io16.unsorted[e] = drv_vec[2][e];

    always_comb begin
        for (int k = 0; k < 3; k++)
            for (int e = 0; e < 16; e++) mon_sorted[k][e] = 64'd0;
        for (int e = 0; e < 4;  e++) mon_sorted[0][e] = io4.sorted[e];
        for (int e = 0; e < 2;  e++) mon_sorted[1][e] = io2.sorted[e];
        for (int e = 0; e < 16; e++) mon_sorted[2][e] = io16.sorted[e];
        mon_valid[0] = io4.valid_out;  mon_err[0] = io4.err;  mon_busy[0] = io4.busy;
        mon_valid[1] = io2.valid_out;  mon_err[1] = io2.err;  mon_busy[1] = io2.busy;
        mon_valid[2] = io16.valid_out; mon_err[2] = io16.err; mon_busy[2] = io16.busy;
    end

    task automatic chk(input string what, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", what, k, cyc, got, exp);
        end
    endtask

    // Compare process: every cycle, every instance.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                int bad;
                if (cyc == reset_cyc) begin
                    for (int e = 0; e < 16; e++) hold_vec[k][e] = 64'd0;
                    hold_err[k] = 1'b0;
                end
                if (cyc == exp_cyc[k]) begin
                    hold_vec[k] = exp_vec[k];
                    hold_err[k] = exp_err[k];
                end
                chk("valid_out", k, 64'(mon_valid[k]), 64'(cyc == exp_cyc[k]));
                chk("busy", k, 64'(mon_busy[k]), 64'(cyc > acc_cyc[k] && cyc <= busy_end[k]));
                chk("err", k, 64'(mon_err[k]), 64'(hold_err[k]));
                bad = 0;
                for (int e = 15; e >= 0; e--)
                    if (mon_sorted[k][e] !== hold_vec[k][e]) bad = e;
                chk("sorted", k, mon_sorted[k][bad], hold_vec[k][bad]);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_job(input int k, input vec_t v, input bit desc, input vec_t ev, input logic ee);
        for (int e = 0; e < 16; e++) drv_vec[k][e] = v[e];
        drv_desc[k]  = desc;
        drv_valid[k] = 1'b1;
        acc_cyc[k]   = cyc;
        exp_cyc[k]   = cyc + lat_lit[k];
        busy_end[k]  = exp_cyc[k];
        exp_vec[k]   = ev;
        exp_err[k]   = ee;
        @(posedge clk);
        #1;
        drv_valid[k] = 1'b0;
    endtask

    task automatic run_job(input int k, input vec_t v, input bit desc, input vec_t ev, input logic ee);
        start_job(k, v, desc, ev, ee);
        goto(exp_cyc[k] + 1);
    endtask

    task automatic run_model(input int k, input vec_t v, input bit desc);
        run_job(k, v, desc, model_sort(v, nn[k], desc), 1'b0);
    endtask

    task automatic chk_model(input string what, input vec_t v, input int n, input bit desc, input vec_t lit);
        vec_t r;
        r = model_sort(v, n, desc);
        for (int i = 0; i < n; i++) chk(what, -1, r[i], lit[i]);
    endtask

    initial begin
        vec_t v, r;
        int t0;
        for (int k = 0; k < 3; k++) begin
            drv_valid[k] = 1'b0;
            drv_desc[k]  = 1'b0;
            for (int e = 0; e < 16; e++) begin
                drv_vec[k][e]  = 64'd0;
                hold_vec[k][e] = 64'd0;
                exp_vec[k][e]  = 64'd0;
            end
            hold_err[k] = 1'b0;
            exp_err[k]  = 1'b0;
            exp_cyc[k]  = -1;
            acc_cyc[k]  = -100;
            busy_end[k] = -100;
        end
        reset_cyc = -1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;

        // Pin the model and the latency helper with hand-computed values
        chk_model("model_asc",  mk4(P3, M1, P2, P1), 4, 1'b0, mk4(M1, P1, P2, P3));
        chk_model("model_desc", mk4(P3, M1, P2, P1), 4, 1'b1, mk4(P3, P2, P1, M1));
        chk_model("model_tie",  mk4(MZ, P1, PZ, M1), 4, 1'b0, mk4(M1, MZ, PZ, P1));
        chk_model("model_n2",   mk4(M1, P2, 0, 0),   2, 1'b1, mk4(P2, M1, 0, 0));
        for (int k = 0; k < 3; k++)
            chk("latency_fn", k, 64'(num_compares(nn[k]) + 1), 64'(lat_lit[k]));

        // N=4 ascending, ignored pulse at T+3, descending accept at T+8
        t0 = cyc;
        start_job(0, mk4(P3, M1, P2, P1), 1'b0, mk4(M1, P1, P2, P3), 1'b0);
        goto(t0 + 3);
        for (int e = 0; e < 4; e++) drv_vec[0][e] = (e == 0) ? P1 : M1;
        drv_desc[0]  = 1'b1;
        drv_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        goto(t0 + 8);
        start_job(0, mk4(P3, M1, P2, P1), 1'b1, mk4(P3, P2, P1, M1), 1'b0);
        goto(exp_cyc[0] + 1);

        // NaN jobs and clean follow-ups, including +0/-0 ties
        run_job(0, mk4(P3, QNAN, P2, P1), 1'b0, mk4(P3, QNAN, P1, P2), 1'b1);
        run_job(0, mk4(PZ, MZ, P1, M1),   1'b1, mk4(P1, PZ, MZ, M1),   1'b0);
        run_model(0, mk4(MZ, P1, PZ, M1), 1'b0);
        run_job(0, mk4(QNAN, P1, P2, P3), 1'b0, mk4(QNAN, P1, P2, P3), 1'b1);

        // Reset in the middle of a job
        t0 = cyc;
        start_job(0, mk4(P2, P1, P3, M1), 1'b0, mk4(M1, P1, P2, P3), 1'b0);
        goto(t0 + 4);
        rst         = 1'b1;
        exp_cyc[0]  = -1;
        busy_end[0] = cyc;
        reset_cyc   = cyc + 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        goto(cyc + 2);
        run_job(0, mk4(P2, P1, P3, M1), 1'b0, mk4(M1, P1, P2, P3), 1'b0);

        // N=2: sorted, reversed, both orders, then random
        run_model(1, mk4(P1, P2, 0, 0), 1'b0);
        run_model(1, mk4(P2, P1, 0, 0), 1'b0);
        run_model(1, mk4(P1, P2, 0, 0), 1'b1);
        run_model(1, mk4(P2, P1, 0, 0), 1'b1);
        for (int i = 0; i < 6; i++) run_model(1, mk4(rnd_f(), rnd_f(), 0, 0), 1'(i % 2));

        // N=16: already sorted, reverse sorted, random
        for (int i = 0; i < 16; i++) begin
            v[i] = $realtobits(real'(i) - 7.5);
            r[15 - i] = v[i];
        end
        run_model(2, v, 1'b0);
        run_model(2, v, 1'b1);
        run_model(2, r, 1'b0);
        run_model(2, r, 1'b1);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 16; i++) v[i] = rnd_f();
            run_model(2, v, 1'(j));
        end

        goto(cyc + 3);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
